// File: rtl/voice_pkg.sv
// Shared constants, word codes and receiver state type for the voice front end.
package voice_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ID_W   = 6;
   localparam int unsigned ERR_W  = 8;

   localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hAA;
   localparam logic [BYTE_W-1:0] CHK_KEY  = 8'h55;
   localparam logic [BYTE_W-1:0] MAX_ID   = 8'd47;

   // Word codes shared with the downstream display sequencer
   localparam logic [ID_W-1:0] ID_IDLE  = 6'd0;
   localparam logic [ID_W-1:0] ID_START = 6'd5;
   localparam logic [ID_W-1:0] ID_DONE  = 6'd46;
   localparam logic [ID_W-1:0] ID_NEXT  = 6'd47;

   typedef enum logic [1:0] {
      WAIT_HDR = 2'd0,
      GET_ID   = 2'd1,
      GET_CHK  = 2'd2
   } rx_state_t;

   // A frame is good when the checksum matches and the full ID byte is in range
   // (the 8-bit compare also rejects any ID byte with bit 7 or bit 6 set).
   function automatic logic frame_ok(input logic [BYTE_W-1:0] id_byte,
                                     input logic [BYTE_W-1:0] chk_byte);
      return (chk_byte == (id_byte ^ CHK_KEY)) && (id_byte <= MAX_ID);
   endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and pulses 'expired'
// in the cycle the count reaches TIMEOUT_CYCLES.
module frame_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Next count; the expiry flag is set one edge early so it lines up with the
   // cycle in which the count equals TIMEOUT_CYCLES.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      if (clear || !enable) begin
         cnt_d = '0;
      end else begin
         if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         expired_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   // Counter and expiry registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/voice_frame_receiver.sv
// Voice frame receiver: turns AA/ID/checksum byte frames into a held word ID
// with a valid strobe, dropping and flagging corrupt or stalled frames.
// Optional build macro ERR_COUNT_EN enables the saturating reject counter;
// without it err_count is tied to zero.
module voice_frame_receiver
   import voice_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [5:0] ID,
   output logic       id_valid,
   output logic       frame_err,
   output logic [7:0] err_count
);

   rx_state_t          state_q, state_d;
   logic [BYTE_W-1:0]  id_byte_q, id_byte_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               id_valid_q, id_valid_d;
   logic               frame_err_q, frame_err_d;
   logic               expired;

   frame_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (rx_valid),
      .enable  (state_q != WAIT_HDR),
      .expired (expired)
   );

   // Frame parser: next state and next outputs; a byte always beats the timeout
   always_comb begin
      state_d     = state_q;
      id_byte_d   = id_byte_q;
      id_d        = id_q;
      id_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         WAIT_HDR: begin
            if (rx_valid && (rx_data == HDR_BYTE)) begin
               state_d = GET_ID;
            end
         end
         GET_ID: begin
            if (rx_valid) begin
               if (rx_data != HDR_BYTE) begin
                  id_byte_d = rx_data;
                  state_d   = GET_CHK;
               end
            end else if (expired) begin
               frame_err_d = 1'b1;
               state_d     = WAIT_HDR;
            end
         end
         GET_CHK: begin
            if (rx_valid) begin
               if (frame_ok(id_byte_q, rx_data)) begin
                  id_d       = id_byte_q[ID_W-1:0];
                  id_valid_d = 1'b1;
                  state_d    = WAIT_HDR;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = (rx_data == HDR_BYTE) ? GET_ID : WAIT_HDR;
               end
            end else if (expired) begin
               frame_err_d = 1'b1;
               state_d     = WAIT_HDR;
            end
         end
         default: begin
            state_d = WAIT_HDR;
         end
      endcase
   end

   // Parser state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_HDR;
         id_byte_q   <= '0;
         id_q        <= ID_IDLE;
         id_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_byte_q   <= id_byte_d;
         id_q        <= id_d;
         id_valid_q  <= id_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign ID        = id_q;
   assign id_valid  = id_valid_q;
   assign frame_err = frame_err_q;

`ifdef ERR_COUNT_EN
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating reject count, advanced alongside the frame_err pulse
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   // Reject counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_voice_frame_receiver.sv
// Self-checking bench for voice_frame_receiver: frame-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_voice_frame_receiver;

   localparam int unsigned TB_T = 20;
`ifdef ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [5:0] ID;
   logic       id_valid;
   logic       frame_err;
   logic [7:0] err_count;

   voice_frame_receiver #(
      .TIMEOUT_CYCLES (TB_T)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .ID        (ID),
      .id_valid  (id_valid),
      .frame_err (frame_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: works on whole frames (header seen, ID collected, idle gap)
   bit         m_in = 1'b0;
   bit         m_have = 1'b0;
   logic [7:0] m_id = 8'h00;
   int         m_idle = 0;
   logic [5:0] e_id = 6'd0;
   bit         e_valid = 1'b0;
   bit         e_err = 1'b0;
   int         e_cnt = 0;

   always @(posedge clk) begin
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (reset) begin
         m_in = 1'b0; m_have = 1'b0; m_idle = 0; e_id = 6'd0; e_cnt = 0;
      end else if (rx_valid) begin
         m_idle = 0;
         if (!m_in) begin
            if (rx_data == 8'hAA) begin m_in = 1'b1; m_have = 1'b0; end
         end else if (!m_have) begin
            if (rx_data != 8'hAA) begin m_id = rx_data; m_have = 1'b1; end
         end else begin
            if ((rx_data == (m_id ^ 8'h55)) && (m_id < 8'd48)) begin
               e_id = m_id[5:0]; e_valid = 1'b1; m_in = 1'b0;
            end else begin
               e_err = 1'b1; m_in = (rx_data == 8'hAA);
            end
            m_have = 1'b0;
         end
      end else if (m_in) begin
         // counter reads 0 in the first idle cycle and TB_T in idle cycle TB_T+1
         m_idle++;
         if (m_idle == TB_T + 1) begin
            e_err = 1'b1; m_in = 1'b0; m_have = 1'b0; m_idle = 0;
         end
      end
      if (e_err && CNT_EN && e_cnt < 255) e_cnt++;
   end

   // Per-cycle compare against the model, plus pulse bookkeeping
   int         vcnt = 0;
   int         ecnt = 0;
   logic [5:0] vq[$];

   always @(negedge clk) begin
      chk("ID", 32'(ID), 32'(e_id));
      chk("id_valid", 32'(id_valid), 32'(e_valid));
      chk("frame_err", 32'(frame_err), 32'(e_err));
      chk("err_count", 32'(err_count), 32'(e_cnt));
      if (id_valid === 1'b1) begin vcnt++; vq.push_back(ID); end
      if (frame_err === 1'b1) ecnt++;
   end

   // Called at a negedge; the byte is sampled at the following posedge
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int e0, v0, k;

   initial begin
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(50);
      chk("reset_ID", 32'(ID), 32'd0);
      chk("reset_err_count", 32'(err_count), 32'd0);
      chk("reset_no_valid", 32'(vcnt), 32'd0);
      chk("reset_no_err", 32'(ecnt), 32'd0);

      // back-to-back good frames
      send(8'hAA); send(8'h05); send(8'h50);
      send(8'hAA); send(8'h0D); send(8'h58);
      send(8'hAA); send(8'h2E); send(8'h7B);
      idle(3);
      chk("good_pulses", 32'(vcnt), 32'd3);
      chk("good_seq0", 32'(vq[0]), 32'd5);
      chk("good_seq1", 32'(vq[1]), 32'd13);
      chk("good_seq2", 32'(vq[2]), 32'd46);
      chk("good_no_err", 32'(ecnt), 32'd0);

      // bad checksum, then out-of-range ID
      send(8'hAA); send(8'h23); send(8'h00);
      send(8'hAA); send(8'h30); send(8'h65);
      idle(3);
      chk("bad_err_pulses", 32'(ecnt), 32'd2);
      chk("bad_err_count", 32'(err_count), CNT_EN ? 32'd2 : 32'd0);
      chk("bad_ID_held", 32'(ID), 32'd46);

      // timeout in GET_CHK: frame_err visible TB_T+1 negedges after the ID byte
      send(8'hAA); send(8'h2C);
      k = 0;
      while (k < int'(TB_T) + 10) begin
         @(negedge clk);
         k++;
         if (frame_err === 1'b1) break;
      end
      chk("timeout_latency", 32'(k), 32'(TB_T + 1));
      idle(2);
      chk("timeout_err_pulses", 32'(ecnt), 32'd3);
      send(8'hAA); send(8'h2C); send(8'h79);
      idle(2);
      chk("after_timeout_ID", 32'(ID), 32'd44);

      // checksum byte arrives in the very cycle the timeout would fire
      send(8'hAA); send(8'h10);
      idle(TB_T);
      send(8'h45);
      idle(2);
      chk("byte_wins_ID", 32'(ID), 32'd16);
      chk("byte_wins_no_err", 32'(ecnt), 32'd3);

      // leading junk and repeated headers
      send(8'h12); send(8'hAA); send(8'hAA); send(8'h2F); send(8'h7A);
      idle(2);
      chk("resync_ID", 32'(ID), 32'd47);
      chk("resync_no_err", 32'(ecnt), 32'd3);

      // rejected frame whose checksum byte is a header restarts collection
      send(8'hAA); send(8'h07); send(8'hAA); send(8'h07); send(8'h52);
      idle(2);
      chk("chk_hdr_ID", 32'(ID), 32'd7);
      chk("chk_hdr_err", 32'(ecnt), 32'd4);

      // reset in the middle of a frame
      v0 = vcnt; e0 = ecnt;
      send(8'hAA); send(8'h05);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      send(8'h50);
      idle(3);
      chk("midreset_ID", 32'(ID), 32'd0);
      chk("midreset_no_valid", 32'(vcnt - v0), 32'd0);
      chk("midreset_no_err", 32'(ecnt - e0), 32'd0);

      // 260 rejected frames: counter saturates (or stays 0 without the counter)
      e0 = ecnt;
      for (int i = 0; i < 260; i++) begin
         send(8'hAA); send(8'h01); send(8'h00);
      end
      idle(3);
      chk("sat_err_pulses", 32'(ecnt - e0), 32'd260);
      chk("sat_err_count", 32'(err_count), CNT_EN ? 32'd255 : 32'd0);
      chk("sat_ID_held", 32'(ID), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
